// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the multi-channel clock divider.
//   CLKDIV_CNT_W_DEF : default counter / half-period width
//   CLKDIV_HALF_DEF  : default half-period terminal count (100 MHz -> 1 kHz)
//   clkdiv_idx_w()   : channel index width, never less than 1 bit
package clkdiv_pkg;

    localparam int unsigned CLKDIV_CNT_W_DEF = 32;
    localparam int unsigned CLKDIV_HALF_DEF  = 49999;

    function automatic int unsigned clkdiv_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if: configuration write channel of clkdiv_multi.
//   cfg_valid : write request (master -> slave)
//   cfg_ch    : target channel index (master -> slave)
//   cfg_half  : new half-period terminal count (master -> slave)
//   cfg_ready : pending slot free (slave -> master)
interface clkdiv_multi_if
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CLKDIV_CNT_W_DEF
) ();

    localparam int unsigned CH_W = clkdiv_idx_w(NUM_CH);

    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;

    modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);

endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel, all state on the falling edge of in_clk.
//   in_clk    : system clock
//   rst       : synchronous active-high reset
//   en        : run enable; low holds cnt at 0 and forces out_clk low
//   load      : replace half with load_half on this edge
//   load_half : new half-period terminal count
//   term      : counter is at its terminal count this cycle (used for load decode)
//   out_clk   : divided clock, registered
//   tick      : one-cycle strobe on every toggle (only with CLKDIV_TICK_EN)
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W        = CLKDIV_CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(CLKDIV_HALF_DEF)
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    output logic             term,
    output logic             out_clk
`ifdef CLKDIV_TICK_EN
    ,
    output logic             tick
`endif
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             out_clk_q, out_clk_d;
`ifdef CLKDIV_TICK_EN
    logic             tick_q, tick_d;
`endif

    assign term = en && (cnt_q == half_q);

    // load is only ever asserted at a wrap or while disabled, i.e. when cnt
    // is headed to 0, so a shrinking half can never strand cnt above it.
    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        out_clk_d = out_clk_q;
`ifdef CLKDIV_TICK_EN
        tick_d    = 1'b0;
`endif
        if (load) begin
            half_d = load_half;
        end
        if (!en) begin
            cnt_d     = '0;
            out_clk_d = 1'b0;
        end else if (term) begin
            cnt_d     = '0;
            out_clk_d = ~out_clk_q;
`ifdef CLKDIV_TICK_EN
            tick_d    = 1'b1;
`endif
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge in_clk) begin
        if (rst) begin
            cnt_q     <= '0;
            half_q    <= DEFAULT_HALF;
            out_clk_q <= 1'b0;
`ifdef CLKDIV_TICK_EN
            tick_q    <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            out_clk_q <= out_clk_d;
`ifdef CLKDIV_TICK_EN
            tick_q    <= tick_d;
`endif
        end
    end

    assign out_clk = out_clk_q;
`ifdef CLKDIV_TICK_EN
    assign tick = tick_q;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH independent runtime-programmable clock dividers.
//   in_clk  : 100 MHz system clock; all logic on its falling edge
//   rst     : synchronous active-high reset
//   ch_en   : per-channel run enable
//   cfg     : clkdiv_multi_if.slave configuration write port (valid/ch/half/ready)
//   out_clk : divided clocks, registered
//   tick    : per-channel toggle strobe, present only when CLKDIV_TICK_EN is defined
// A single pending slot {ch, half} holds one write until the target channel
// wraps (or immediately if it is disabled), which keeps reprogramming glitch-free.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned      NUM_CH       = 4,
    parameter int unsigned      CNT_W        = CLKDIV_CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(CLKDIV_HALF_DEF)
) (
    input  logic              in_clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    clkdiv_multi_if.slave     cfg,
    output logic [NUM_CH-1:0] out_clk
`ifdef CLKDIV_TICK_EN
    ,
    output logic [NUM_CH-1:0] tick
`endif
);

    localparam int unsigned CH_W = clkdiv_idx_w(NUM_CH);

    logic             slot_valid_q, slot_valid_d;
    logic [CH_W-1:0]  slot_ch_q, slot_ch_d;
    logic [CNT_W-1:0] slot_half_q, slot_half_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] load;
    logic              accept;
    logic              ch_in_range;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign load[g] = slot_valid_q && (slot_ch_q == CH_W'(g)) && (term[g] || !ch_en[g]);

        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .in_clk    (in_clk),
            .rst       (rst),
            .en        (ch_en[g]),
            .load      (load[g]),
            .load_half (slot_half_q),
            .term      (term[g]),
            .out_clk   (out_clk[g])
`ifdef CLKDIV_TICK_EN
            ,
            .tick      (tick[g])
`endif
        );
    end

    always_comb begin
        accept      = cfg.cfg_valid && cfg_ready_q;
        ch_in_range = 32'(cfg.cfg_ch) < NUM_CH;

        slot_valid_d = slot_valid_q;
        slot_ch_d    = slot_ch_q;
        slot_half_d  = slot_half_q;

        if (|load) begin
            slot_valid_d = 1'b0;
        end
        // Out-of-range writes complete the handshake but never occupy the slot.
        if (accept && ch_in_range) begin
            slot_valid_d = 1'b1;
            slot_ch_d    = cfg.cfg_ch;
            slot_half_d  = cfg.cfg_half;
        end

        // Ready drops with the fill and rises one edge after the slot clears.
        cfg_ready_d = !slot_valid_d && !slot_valid_q;
    end

    always_ff @(negedge in_clk) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_ch_q    <= '0;
            slot_half_q  <= '0;
            cfg_ready_q  <= 1'b1;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_ch_q    <= slot_ch_d;
            slot_half_q  <= slot_half_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: self-checking bench for clkdiv_multi.
// Expected toggle events {channel, cycle, level, tick} are queued when the
// stimulus that causes them is driven; every observed out_clk change is
// matched against the oldest queued event for that channel.
module tb_clkdiv_multi;
    import clkdiv_pkg::*;

    // Five channels so that cfg_ch = 7 is representable yet out of range.
    localparam int unsigned NCH = 5;
    localparam int unsigned CW  = 32;
    localparam int unsigned CHW = clkdiv_idx_w(NCH);

    logic           in_clk = 1'b1;
    logic           rst;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] out_clk;
`ifdef CLKDIV_TICK_EN
    logic [NCH-1:0] tick;
`endif

    clkdiv_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_if ();

    clkdiv_multi #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .DEFAULT_HALF (32'd9)
    ) dut (
        .in_clk  (in_clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .cfg     (cfg_if.slave),
        .out_clk (out_clk)
`ifdef CLKDIV_TICK_EN
        ,
        .tick    (tick)
`endif
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int unsigned ch;
        int unsigned at;
        logic        lvl;
        logic        tk;
    } ev_t;

    ev_t            sbq[$];
    int unsigned    cyc;
    int unsigned    total;
    int unsigned    bad;
    logic [NCH-1:0] prev_out;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic push_ev(input int unsigned ch, input int unsigned at, input logic lvl, input logic tk);
        ev_t e;
        e.ch  = ch;
        e.at  = at;
        e.lvl = lvl;
        e.tk  = tk;
        sbq.push_back(e);
    endtask

    // Advance one cycle; sample on the rising edge, opposite the DUT's edge.
    task automatic step();
        ev_t e;
        int  idx;
        int  n;
        @(posedge in_clk);
        cyc++;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (out_clk[c] !== prev_out[c]) begin
                idx = -1;
                for (int i = 0; i < sbq.size(); i++)
                    if (idx < 0 && sbq[i].ch == c) idx = i;
                if (idx < 0) begin
                    check_eq("spur_tog", out_clk[c], prev_out[c]);
                end else begin
                    e = sbq[idx];
                    sbq.delete(idx);
                    check_eq("tog_cyc", cyc, e.at);
                    check_eq("tog_lvl", out_clk[c], e.lvl);
`ifdef CLKDIV_TICK_EN
                    check_eq("tog_tick", tick[c], e.tk);
`endif
                end
            end
`ifdef CLKDIV_TICK_EN
            else check_eq("idle_tick", tick[c], 1'b0);
`endif
        end
        n = 0;
        while (n < sbq.size()) begin
            if (sbq[n].at < cyc) begin
                check_eq("missed_tog", cyc, sbq[n].at);
                sbq.delete(n);
            end else begin
                n++;
            end
        end
        prev_out = out_clk;
    endtask

    task automatic run_to(input int unsigned target);
        while (cyc < target) step();
    endtask

    task automatic cfg_write(input int unsigned ch, input int unsigned half);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CHW'(ch);
        cfg_if.cfg_half  = CW'(half);
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    int unsigned r, t, k, e, f, g;

    initial begin
        rst              = 1'b1;
        ch_en            = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_half  = '0;
        cyc      = 0;
        total    = 0;
        bad      = 0;
        prev_out = '0;

        // Reset state; a write during reset must be dropped.
        step(); step(); step();
        check_eq("rst_out", out_clk, 0);
        check_eq("rst_rdy", cfg_if.cfg_ready, 1);
        cfg_write(0, 1);
        check_eq("rst_wr_rdy", cfg_if.cfg_ready, 1);

        // Default half (9): ch0 rises 10 cycles after reset release, period 20.
        ch_en = 5'b00001;
        rst   = 1'b0;
        r     = cyc;
        push_ev(0, r + 10, 1'b1, 1'b1);
        push_ev(0, r + 20, 1'b0, 1'b1);
        push_ev(0, r + 30, 1'b1, 1'b1);
        push_ev(0, r + 40, 1'b0, 1'b1);
        run_to(r + 40);

        // Running ch0 at half 9 reprogrammed to 4: current half-period finishes.
        t = cyc;
        cfg_write(0, 4);
        check_eq("run_wr_rdy0", cfg_if.cfg_ready, 0);
        push_ev(0, t + 10, 1'b1, 1'b1);
        push_ev(0, t + 15, 1'b0, 1'b1);
        push_ev(0, t + 20, 1'b1, 1'b1);
        push_ev(0, t + 25, 1'b0, 1'b1);
        run_to(t + 10);
        check_eq("run_apply_rdy0", cfg_if.cfg_ready, 0);
        step();
        check_eq("run_apply_rdy1", cfg_if.cfg_ready, 1);

        // Write sampled on ch0's terminal edge: old half used once more.
        run_to(t + 19);
        cfg_write(0, 7);
        check_eq("tc_wr_rdy0", cfg_if.cfg_ready, 0);
        push_ev(0, t + 33, 1'b1, 1'b1);
        push_ev(0, t + 41, 1'b0, 1'b1);
        run_to(t + 26);
        check_eq("tc_apply_rdy1", cfg_if.cfg_ready, 1);
        run_to(t + 41);
        ch_en = '0;

        // Disabled ch1 set to half 2: ready back two cycles after acceptance.
        k = cyc;
        cfg_write(1, 2);
        check_eq("dis_rdy_k1", cfg_if.cfg_ready, 0);
        step();
        check_eq("dis_rdy_k2", cfg_if.cfg_ready, 0);
        step();
        check_eq("dis_rdy_k3", cfg_if.cfg_ready, 1);
        e     = cyc;
        ch_en = 5'b00010;
        push_ev(1, e + 3, 1'b1, 1'b1);
        push_ev(1, e + 6, 1'b0, 1'b1);
        push_ev(1, e + 9, 1'b1, 1'b1);
        run_to(e + 10);
        // Dropping enable mid-high forces the output low on the next edge.
        ch_en = '0;
        push_ev(1, e + 11, 1'b0, 1'b0);
        run_to(e + 14);

        // half 0 on ch2: divide-by-2, then disable while high.
        cfg_write(2, 0);
        step();
        step();
        check_eq("div2_rdy", cfg_if.cfg_ready, 1);
        f     = cyc;
        ch_en = 5'b00100;
        push_ev(2, f + 1, 1'b1, 1'b1);
        push_ev(2, f + 2, 1'b0, 1'b1);
        push_ev(2, f + 3, 1'b1, 1'b1);
        push_ev(2, f + 4, 1'b0, 1'b1);
        push_ev(2, f + 5, 1'b1, 1'b1);
        run_to(f + 5);
        ch_en = '0;
        push_ev(2, f + 6, 1'b0, 1'b0);
        run_to(f + 8);

        // Out-of-range channel: accepted, discarded, slot stays free.
        cfg_write(7, 0);
        check_eq("oor_rdy1", cfg_if.cfg_ready, 1);
        step();
        check_eq("oor_rdy2", cfg_if.cfg_ready, 1);

        // Second write while the slot is full must be ignored.
        cfg_write(3, 2);
        check_eq("full_rdy0", cfg_if.cfg_ready, 0);
        cfg_write(3, 5);
        check_eq("full_rdy1", cfg_if.cfg_ready, 0);
        step();
        check_eq("full_rdy2", cfg_if.cfg_ready, 1);
        e     = cyc;
        ch_en = 5'b01000;
        push_ev(3, e + 3, 1'b1, 1'b1);
        push_ev(3, e + 6, 1'b0, 1'b1);
        push_ev(3, e + 9, 1'b1, 1'b1);
        run_to(e + 9);
        ch_en = '0;
        push_ev(3, e + 10, 1'b0, 1'b0);
        run_to(e + 12);

        // Reset mid-period with a pending write: write lost, halves back to 9.
        ch_en = 5'b00001;
        g     = cyc;
        cfg_write(0, 1);
        check_eq("mid_wr_rdy0", cfg_if.cfg_ready, 0);
        step();
        rst = 1'b1;
        step();
        check_eq("mid_rst_rdy", cfg_if.cfg_ready, 1);
        check_eq("mid_rst_out", out_clk, 0);
        step();
        rst = 1'b0;
        r   = cyc;
        push_ev(0, r + 10, 1'b1, 1'b1);
        push_ev(0, r + 20, 1'b0, 1'b1);
        push_ev(0, r + 30, 1'b1, 1'b1);
        run_to(r + 32);

        check_eq("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
